memory_multiport: RTL and testbench

Parametrised multi-read-port RAM. It is the next-generation replacement for the single-port activation/weight memory in the accelerator datapath.
- One write port and READ_PORTS independent synchronous read ports.
- Per-port read-valid flags.
- Write-first read-during-write behaviour.
- A hardware clear sequencer replaces simulation-only zero initialisation, so clearing is synthesisable and can be re-triggered at runtime, e.g. between layers.

---
 rtl/memory_multiport.sv | 119 +++++++++++
 tb/tb_memory_multiport.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_multiport.sv
// Multi-read-port RAM: one write port, READ_PORTS synchronous write-first read ports, hardware clear sweep.
// Optional macro MEMORY_MULTIPORT_OUTREG_EN adds a second output register stage (read latency 2).
module memory_multiport #(
    parameter int DEPTH          = 8,
    parameter int BIT_SIZE       = 16,
    parameter int READ_PORTS     = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           write_enable,
    input  logic [DEPTH-1:0]               write_addr,
    input  logic [BIT_SIZE-1:0]            data_in,
    input  logic [READ_PORTS-1:0]          read_enable,
    input  logic [READ_PORTS*DEPTH-1:0]    read_addr,
    input  logic                           clear_req,
    output logic [READ_PORTS*BIT_SIZE-1:0] data_out,
    output logic [READ_PORTS-1:0]          data_valid,
    output logic                           ready
);

    localparam int WORDS = 2 ** DEPTH;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    state_t                         state;
    state_t                         next_state;
    logic [DEPTH-1:0]               clear_cnt;
    logic [BIT_SIZE-1:0]            mem [WORDS];
    logic [READ_PORTS*BIT_SIZE-1:0] rd_data;
    logic [READ_PORTS-1:0]          rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clear_cnt == '1) next_state = RUN;
            RUN:     if (clear_req) next_state = CLEAR;
            default: next_state = RESET_STATE;
        endcase
    end

    // Counter wraps to 0 on the final sweep address, so it is already 0 for the next sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_cnt <= '0;
        end else if (state == CLEAR) begin
            clear_cnt <= clear_cnt + 1'b1;
        end else begin
            clear_cnt <= '0;
        end
    end

    // Storage has no reset; the rst gate keeps the held CLEAR state from sweeping during reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clear_cnt] <= '0;
            end else if (write_enable) begin
                mem[write_addr] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            for (int unsigned p = 0; p < READ_PORTS; p++) begin
                if (state == RUN && read_enable[p]) begin
                    rd_data[p*BIT_SIZE +: BIT_SIZE] <=
                        (write_enable && write_addr == read_addr[p*DEPTH +: DEPTH])
                            ? data_in : mem[read_addr[p*DEPTH +: DEPTH]];
                    rd_valid[p] <= 1'b1;
                end else begin
                    rd_valid[p] <= 1'b0;
                end
            end
        end
    end

`ifdef MEMORY_MULTIPORT_OUTREG_EN
    logic [READ_PORTS*BIT_SIZE-1:0] out_data;
    logic [READ_PORTS-1:0]          out_valid;

    // Forwarding is already resolved in the first stage; this stage only delays it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= '0;
        end else begin
            out_data  <= rd_data;
            out_valid <= (state == RUN) ? rd_valid : '0;
        end
    end

    assign data_out   = out_data;
    assign data_valid = out_valid;
`else
    assign data_out   = rd_data;
    assign data_valid = rd_valid;
`endif

    assign ready = (state == RUN) && !rst;

endmodule

// File: tb/tb_memory_multiport.sv
// Self-checking bench for memory_multiport (DEPTH=4, BIT_SIZE=8, READ_PORTS=2): directed plan plus random traffic.
module tb_memory_multiport;

    localparam int DEPTH      = 4;
    localparam int BIT_SIZE   = 8;
    localparam int READ_PORTS = 2;
    localparam int WORDS      = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  din;
    logic [1:0]  re;
    logic [7:0]  ra;
    logic        clear_req;
    logic [15:0] dout;
    logic [1:0]  dvalid;
    logic        ready;

    always #5 clk = ~clk;

    memory_multiport #(
        .DEPTH(DEPTH),
        .BIT_SIZE(BIT_SIZE),
        .READ_PORTS(READ_PORTS),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .write_enable(we),
        .write_addr(wa),
        .data_in(din),
        .read_enable(re),
        .read_addr(ra),
        .clear_req(clear_req),
        .data_out(dout),
        .data_valid(dvalid),
        .ready(ready)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    // Reference model: word array, remaining sweep cycles, expected read results.
    logic [7:0] mdl_mem [WORDS];
    logic [7:0] exp_out [2];
    logic [1:0] exp_valid  = 2'b00;
    int         clear_left = 16;
    logic [3:0] m_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_out[0] = 8'h00;
        exp_out[1] = 8'h00;
        for (int i = 0; i < WORDS; i++) mdl_mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (rst) begin
            clear_left = 16;
            exp_valid  = 2'b00;
            exp_out[0] = 8'h00;
            exp_out[1] = 8'h00;
        end else if (clear_left > 0) begin
            exp_valid = 2'b00;
            clear_left--;
            if (clear_left == 0)
                for (int i = 0; i < WORDS; i++) mdl_mem[i] = 8'h00;
        end else begin
            for (int p = 0; p < 2; p++) begin
                m_addr = ra[p*4 +: 4];
                if (re[p]) exp_out[p] = (we && wa == m_addr) ? din : mdl_mem[m_addr];
                exp_valid[p] = re[p];
            end
            if (we) mdl_mem[wa] = din;
            if (clear_req) clear_left = 16;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) begin
                check("rst_data_out", dout, 0);
                check("rst_valid", dvalid, 0);
                check("rst_ready", ready, 0);
            end else begin
                check("ready", ready, clear_left == 0);
                check("valid", dvalid, exp_valid);
                check("data_out_p0", dout[7:0], exp_out[0]);
                check("data_out_p1", dout[15:8], exp_out[1]);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; wa = '0; din = '0; re = '0; ra = '0; clear_req = 1'b0;

        // 1: reset for 3 cycles, then a full 16-cycle sweep
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (!ready && n < 40) begin cyc(); n++; end
        check("sweep_len_after_reset", n, 16);
        for (int i = 0; i < 16; i++) begin
            re = 2'b01;
            ra = 8'(i);
            cyc();
            check("swept_word", dout[7:0], 8'h00);
            check("swept_valid", dvalid, 2'b01);
        end
        re = 2'b00;

        // 2: write then read
        we = 1'b1; wa = 4'd3; din = 8'hA5;
        cyc();
        we = 1'b0; re = 2'b01; ra = 8'h03;
        cyc();
        re = 2'b00;
        check("read_after_write", dout[7:0], 8'hA5);
        check("read_after_write_valid", dvalid, 2'b01);

        // 3: write-first on port 1
        we = 1'b1; wa = 4'd7; din = 8'h3C; re = 2'b10; ra = 8'h70;
        cyc();
        we = 1'b0; re = 2'b00;
        check("write_first_p1", dout[15:8], 8'h3C);
        check("write_first_valid", dvalid, 2'b10);

        // 4: both ports, then idle hold
        re = 2'b11; ra = 8'h73;
        cyc();
        re = 2'b00;
        check("dual_read", dout, 16'h3CA5);
        check("dual_read_valid", dvalid, 2'b11);
        cyc();
        check("idle_valid", dvalid, 2'b00);
        check("idle_hold", dout, 16'h3CA5);

        // 5: runtime clear, write during sweep dropped
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        we = 1'b1; wa = 4'd2; din = 8'h55;
        n = 0;
        while (!ready && n < 40) begin cyc(); we = 1'b0; n++; end
        we = 1'b0;
        check("sweep_len_clear_req", n, 16);
        re = 2'b11; ra = 8'h23;
        cyc();
        check("cleared_2_3", dout, 16'h0000);
        re = 2'b01; ra = 8'h07;
        cyc();
        re = 2'b00;
        check("cleared_7", dout[7:0], 8'h00);

        // 6: reset mid-sweep with clear counter at 5
        we = 1'b1; wa = 4'd5; din = 8'h99;
        cyc();
        we = 1'b0; re = 2'b11; ra = 8'h55; clear_req = 1'b1;
        cyc();
        re = 2'b00; clear_req = 1'b0;
        check("read_on_clear_edge", dout, 16'h9999);
        check("read_on_clear_edge_valid", dvalid, 2'b11);
        repeat (5) cyc();
        rst = 1'b1;
        #1;
        check("async_rst_data_out", dout, 16'h0000);
        check("async_rst_valid", dvalid, 2'b00);
        check("async_rst_ready", ready, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        n = 0;
        while (!ready && n < 40) begin cyc(); n++; end
        check("sweep_len_after_mid_reset", n, 16);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 4'($urandom);
            din = 8'($urandom);
            re  = 2'($urandom);
            ra  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) ra[3:0] = wa;
            if ($urandom_range(0, 3) == 0) ra[7:4] = wa;
            clear_req = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                cyc();
                cyc();
                rst = 1'b0;
            end
            cyc();
        end
        we = 1'b0; re = 2'b00; clear_req = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
